// File: rtl/legv8_pkg.sv
// legv8_pkg: shared encodings, control-word layout and helpers for the LEGv8 sequencer
package legv8_pkg;
  localparam logic [1:0] ST_IDLE = 2'b00, ST_EX0 = 2'b01, ST_EX1 = 2'b10, ST_HALT = 2'b11;
  localparam logic [1:0] PS_HOLD = 2'b00, PS_INC = 2'b01, PS_BR = 2'b10, PS_REG = 2'b11;
  localparam logic [4:0] FS_AND = 5'b00000, FS_ORR = 5'b00100, FS_ADD = 5'b01000, FS_SUB = 5'b01001;
  localparam logic [4:0] FS_EOR = 5'b01100, FS_LSL = 5'b10000, FS_LSR = 5'b10100;
  localparam logic [10:0] OP_ADD = 11'b10001011000, OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000, OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_AND = 11'b10001010000, OP_ANDS = 11'b11101010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000, OP_EOR = 11'b11001010000;
  localparam logic [10:0] OP_LSL = 11'b11010011011, OP_LSR = 11'b11010011010;
  localparam logic [10:0] OP_BR = 11'b11010110000, OP_LDUR = 11'b11111000010, OP_STUR = 11'b11111000000;
  localparam logic [9:0] OP_ADDI = 10'b1001000100, OP_SUBI = 10'b1101000100;
  localparam logic [8:0] OP_MOVZ = 9'b110100101;
  localparam logic [5:0] OP_B = 6'b000101, OP_BL = 6'b100101;
  localparam logic [7:0] OP_CBZ = 8'b10110100, OP_CBNZ = 8'b10110101, OP_BCOND = 8'b01010100;
  localparam logic [3:0] CC_EQ = 4'd0, CC_NE = 4'd1, CC_HS = 4'd2, CC_LO = 4'd3, CC_MI = 4'd4;
  localparam logic [3:0] CC_PL = 4'd5, CC_VS = 4'd6, CC_VC = 4'd7, CC_HI = 4'd8, CC_LS = 4'd9;
  localparam logic [3:0] CC_GE = 4'd10, CC_LT = 4'd11, CC_GT = 4'd12, CC_LE = 4'd13;
  localparam int CW_W = 94;
  localparam int DA_LSB = 0, SA_LSB = 5, SB_LSB = 10, FS_LSB = 15, PS_LSB = 20, WR_BIT = 22;
  localparam int WM_BIT = 23, SL_BIT = 24, BSEL_BIT = 25, PCSEL_BIT = 26, EN_ALU_BIT = 27;
  localparam int EN_MEM_BIT = 28, EN_PC_BIT = 29, K_LSB = 30;
  typedef enum logic [3:0] {
    CL_ILL, CL_ALU, CL_ALUI, CL_SHIFT, CL_MOVZ, CL_LDUR, CL_STUR,
    CL_B, CL_BL, CL_BR, CL_CBZ, CL_CBNZ, CL_BCOND
  } iclass_e;
  typedef struct packed {
    logic [63:0] k;
    logic        en_pc, en_mem, en_alu, pcsel, bsel, sl, wm, wr;
    logic [1:0]  ps;
    logic [4:0]  fs, sb, sa, da;
  } cw_t;
  function automatic logic [CW_W-1:0] pack_cw(cw_t c);
    logic [CW_W-1:0] w;
    w = '0;
    w[K_LSB +: 64] = c.k;
    w[EN_PC_BIT]   = c.en_pc;
    w[EN_MEM_BIT]  = c.en_mem;
    w[EN_ALU_BIT]  = c.en_alu;
    w[PCSEL_BIT]   = c.pcsel;
    w[BSEL_BIT]    = c.bsel;
    w[SL_BIT]      = c.sl;
    w[WM_BIT]      = c.wm;
    w[WR_BIT]      = c.wr;
    w[PS_LSB +: 2] = c.ps;
    w[FS_LSB +: 5] = c.fs;
    w[SB_LSB +: 5] = c.sb;
    w[SA_LSB +: 5] = c.sa;
    w[DA_LSB +: 5] = c.da;
    return w;
  endfunction
  // f = {V,C,N,Z}; codes 14/15 are always
  function automatic logic cond_taken(logic [3:0] cc, logic [3:0] f);
    case (cc)
      CC_EQ: return f[0];
      CC_NE: return ~f[0];
      CC_HS: return f[2];
      CC_LO: return ~f[2];
      CC_MI: return f[1];
      CC_PL: return ~f[1];
      CC_VS: return f[3];
      CC_VC: return ~f[3];
      CC_HI: return f[2] & ~f[0];
      CC_LS: return ~f[2] | f[0];
      CC_GE: return f[1] == f[3];
      CC_LT: return f[1] != f[3];
      CC_GT: return ~f[0] & (f[1] == f[3]);
      CC_LE: return f[0] | (f[1] != f[3]);
      default: return 1'b1;
    endcase
  endfunction
endpackage

// File: rtl/legv8_decode.sv
// legv8_decode: combinational instruction classifier with immediate extraction
module legv8_decode
  import legv8_pkg::*;
(
  input  logic [31:0] instruction_i,
  output iclass_e     cls_o,
  output logic [4:0]  fs_o,
  output logic        sl_o,
  output logic [63:0] imm_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  rn_o,
  output logic [4:0]  rm_o,
  output logic [3:0]  cond_o,
  output logic        illegal_o
);
  logic [31:0] x;
  logic [10:0] op11;
  assign x = instruction_i;
  assign op11 = x[31:21];
  assign rd_o = x[4:0];
  assign rn_o = x[9:5];
  assign rm_o = x[20:16];
  assign cond_o = x[3:0];
  assign illegal_o = cls_o == CL_ILL;
  always_comb begin
    cls_o = CL_ILL;
    fs_o = FS_AND;
    sl_o = 1'b0;
    imm_o = '0;
    if (op11 == OP_ADD || op11 == OP_ADDS) begin
      cls_o = CL_ALU; fs_o = FS_ADD; sl_o = op11 == OP_ADDS;
    end else if (op11 == OP_SUB || op11 == OP_SUBS) begin
      cls_o = CL_ALU; fs_o = FS_SUB; sl_o = op11 == OP_SUBS;
    end else if (op11 == OP_AND || op11 == OP_ANDS) begin
      cls_o = CL_ALU; fs_o = FS_AND; sl_o = op11 == OP_ANDS;
    end else if (op11 == OP_ORR || op11 == OP_EOR) begin
      cls_o = CL_ALU; fs_o = (op11 == OP_ORR) ? FS_ORR : FS_EOR;
    end else if (op11 == OP_LSL || op11 == OP_LSR) begin
      cls_o = CL_SHIFT; fs_o = (op11 == OP_LSL) ? FS_LSL : FS_LSR; imm_o = {58'b0, x[15:10]};
    end else if (op11 == OP_BR) begin
      cls_o = CL_BR; fs_o = FS_ORR;
    end else if (op11 == OP_LDUR || op11 == OP_STUR) begin
      cls_o = (op11 == OP_LDUR) ? CL_LDUR : CL_STUR; fs_o = FS_ADD; imm_o = {{55{x[20]}}, x[20:12]};
    end else if (x[31:22] == OP_ADDI || x[31:22] == OP_SUBI) begin
      cls_o = CL_ALUI; fs_o = (x[31:22] == OP_ADDI) ? FS_ADD : FS_SUB; imm_o = {52'b0, x[21:10]};
    end else if (x[31:23] == OP_MOVZ) begin
      cls_o = CL_MOVZ; fs_o = FS_ORR; imm_o = {48'b0, x[20:5]} << {x[22:21], 4'b0};
    end else if (x[31:26] == OP_B || x[31:26] == OP_BL) begin
      cls_o = (x[31:26] == OP_B) ? CL_B : CL_BL; imm_o = {{38{x[25]}}, x[25:0]};
    end else if (x[31:24] == OP_CBZ || x[31:24] == OP_CBNZ || x[31:24] == OP_BCOND) begin
      cls_o = (x[31:24] == OP_CBZ) ? CL_CBZ : (x[31:24] == OP_CBNZ) ? CL_CBNZ : CL_BCOND;
      fs_o = (x[31:24] == OP_BCOND) ? FS_AND : FS_ORR;
      imm_o = {{45{x[23]}}, x[23:5]};
    end
  end
endmodule

// File: rtl/legv8_sequencer.sv
// legv8_sequencer: multi-cycle LEGv8 control FSM driving the datapath control word
module legv8_sequencer
  import legv8_pkg::*;
#(
  parameter int RESET_IDLE_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [4:0]  status,
  output logic [93:0] control_word,
  output logic        halted,
  output logic [1:0]  state
);
  localparam logic [7:0] IDLE_LAST = 8'(RESET_IDLE_CYCLES - 1);
  logic [1:0] st_q, st_d;
  logic [7:0] cnt_q, cnt_d;
  iclass_e cls;
  logic [4:0] fs, rd, rn, rm;
  logic [3:0] cond;
  logic [63:0] imm;
  logic sl, illegal;
  cw_t c;
  legv8_decode u_decode (
    .instruction_i(instruction),
    .cls_o(cls),
    .fs_o(fs),
    .sl_o(sl),
    .imm_o(imm),
    .rd_o(rd),
    .rn_o(rn),
    .rm_o(rm),
    .cond_o(cond),
    .illegal_o(illegal)
  );
  always_comb begin
    st_d = (st_q == ST_IDLE) ? ((cnt_q == IDLE_LAST) ? ST_EX0 : ST_IDLE) :
           (st_q == ST_EX0)  ? (illegal ? ST_HALT : (cls == CL_LDUR) ? ST_EX1 : ST_EX0) :
           (st_q == ST_EX1)  ? ST_EX0 : ST_HALT;
    cnt_d = (st_q == ST_IDLE && cnt_q != IDLE_LAST) ? cnt_q + 8'd1 : cnt_q;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_q <= ST_IDLE;
      cnt_q <= '0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
    end
  end
  // Mealy: fields come straight from the live instruction/status; EX1 replays the held LDUR
  always_comb begin
    c = '0;
    c.k = imm;
    c.fs = fs;
    c.sl = sl;
    c.da = rd;
    c.sa = rn;
    c.sb = rm;
    case (cls)
      CL_ALU: begin c.en_alu = 1'b1; c.wr = 1'b1; c.ps = PS_INC; end
      CL_ALUI, CL_SHIFT: begin c.bsel = 1'b1; c.en_alu = 1'b1; c.wr = 1'b1; c.ps = PS_INC; end
      CL_MOVZ: begin c.sa = 5'd31; c.bsel = 1'b1; c.en_alu = 1'b1; c.wr = 1'b1; c.ps = PS_INC; end
      CL_LDUR: begin
        c.bsel = 1'b1;
        c.en_mem = st_q == ST_EX1;
        c.wr = st_q == ST_EX1;
        c.ps = (st_q == ST_EX1) ? PS_INC : PS_HOLD;
      end
      CL_STUR: begin c.bsel = 1'b1; c.wm = 1'b1; c.sb = rd; c.ps = PS_INC; end
      CL_B: c.ps = PS_BR;
      CL_BL: begin c.ps = PS_BR; c.en_pc = 1'b1; c.wr = 1'b1; c.da = 5'd30; end
      CL_BR: begin c.sb = 5'd31; c.ps = PS_REG; end
      CL_CBZ, CL_CBNZ: begin
        c.sa = 5'd31;
        c.sb = rd;
        c.ps = (status[0] == (cls == CL_CBZ)) ? PS_BR : PS_INC;
      end
      CL_BCOND: c.ps = cond_taken(cond, status[4:1]) ? PS_BR : PS_INC;
      default: ;
    endcase
    control_word = (st_q == ST_EX1 || (st_q == ST_EX0 && !illegal)) ? pack_cw(c) : '0;
  end
  assign halted = st_q == ST_HALT;
  assign state = st_q;
endmodule

// File: tb/tb_legv8_sequencer.sv
// tb_legv8_sequencer: randomized scoreboard bench against an instruction-level reference model
module tb_legv8_sequencer;
  localparam int IDLE_N = 1;
  localparam int K_ADD = 0, K_ADDS = 1, K_SUB = 2, K_SUBS = 3, K_AND = 4, K_ANDS = 5, K_ORR = 6;
  localparam int K_EOR = 7, K_LSL = 8, K_LSR = 9, K_ADDI = 10, K_SUBI = 11, K_MOVZ = 12, K_LDUR = 13;
  localparam int K_STUR = 14, K_B = 15, K_BL = 16, K_BR = 17, K_CBZ = 18, K_CBNZ = 19, K_BC = 20;
  localparam int K_ILL = 21, K_ILLF = 22;
  typedef struct {
    int kind;
    logic [4:0] rd, rn, rm;
    logic [5:0] sh;
    logic [11:0] i12;
    logic [15:0] i16;
    logic [1:0] hw;
    logic [8:0] dt;
    logic [25:0] i26;
    logic [18:0] i19;
    logic [3:0] cond;
  } op_t;
  typedef struct packed {
    logic [93:0] cw;
    logic [1:0]  st;
    logic        h;
  } exp_t;
  logic clock, reset;
  logic [31:0] instruction;
  logic [4:0] status;
  logic [93:0] control_word;
  logic halted;
  logic [1:0] state;
  exp_t q[$];
  exp_t mon_e;
  int vectors = 0, miscompares = 0;
  int mst = 0, icnt = 0;
  op_t last_op;
  legv8_sequencer #(.RESET_IDLE_CYCLES(IDLE_N)) dut (
    .clock(clock),
    .reset(reset),
    .instruction(instruction),
    .status(status),
    .control_word(control_word),
    .halted(halted),
    .state(state)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  function automatic logic [31:0] enc(op_t o);
    case (o.kind)
      K_ADD:  return {11'b10001011000, o.rm, 6'd0, o.rn, o.rd};
      K_ADDS: return {11'b10101011000, o.rm, 6'd0, o.rn, o.rd};
      K_SUB:  return {11'b11001011000, o.rm, 6'd0, o.rn, o.rd};
      K_SUBS: return {11'b11101011000, o.rm, 6'd0, o.rn, o.rd};
      K_AND:  return {11'b10001010000, o.rm, 6'd0, o.rn, o.rd};
      K_ANDS: return {11'b11101010000, o.rm, 6'd0, o.rn, o.rd};
      K_ORR:  return {11'b10101010000, o.rm, 6'd0, o.rn, o.rd};
      K_EOR:  return {11'b11001010000, o.rm, 6'd0, o.rn, o.rd};
      K_LSL:  return {11'b11010011011, o.rm, o.sh, o.rn, o.rd};
      K_LSR:  return {11'b11010011010, o.rm, o.sh, o.rn, o.rd};
      K_ADDI: return {10'b1001000100, o.i12, o.rn, o.rd};
      K_SUBI: return {10'b1101000100, o.i12, o.rn, o.rd};
      K_MOVZ: return {9'b110100101, o.hw, o.i16, o.rd};
      K_LDUR: return {11'b11111000010, o.dt, 2'b00, o.rn, o.rd};
      K_STUR: return {11'b11111000000, o.dt, 2'b00, o.rn, o.rd};
      K_B:    return {6'b000101, o.i26};
      K_BL:   return {6'b100101, o.i26};
      K_BR:   return {11'b11010110000, 5'd31, 6'd0, o.rn, 5'd0};
      K_CBZ:  return {8'b10110100, o.i19, o.rd};
      K_CBNZ: return {8'b10110101, o.i19, o.rd};
      K_BC:   return {8'b01010100, o.i19, 1'b0, o.cond};
      K_ILLF: return 32'hFFFF_FFFF;
      default: return 32'h0;
    endcase
  endfunction
  function automatic bit taken(logic [3:0] cc, logic [4:0] st);
    bit v, c, n, z;
    {v, c, n, z} = st[4:1];
    case (cc)
      0: return z;
      1: return !z;
      2: return c;
      3: return !c;
      4: return n;
      5: return !n;
      6: return v;
      7: return !v;
      8: return c && !z;
      9: return !c || z;
      10: return n == v;
      11: return n != v;
      12: return !z && n == v;
      13: return z || n != v;
      default: return 1'b1;
    endcase
  endfunction
  function automatic logic [93:0] model_cw(op_t o, logic [31:0] ins, logic [4:0] st, bit ex1);
    logic [63:0] k;
    logic e_pc, e_mem, e_alu, bsel, sl, wm, wr;
    logic [1:0] ps;
    logic [4:0] fs, sb, sa, da;
    {k, e_pc, e_mem, e_alu, bsel, sl, wm, wr, ps, fs} = '0;
    da = ins[4:0];
    sa = ins[9:5];
    sb = ins[20:16];
    if (o.kind <= K_MOVZ) begin
      e_alu = 1'b1; wr = 1'b1; ps = 2'b01;
    end
    case (o.kind)
      K_ADD:  fs = 5'b01000;
      K_ADDS: begin fs = 5'b01000; sl = 1'b1; end
      K_SUB:  fs = 5'b01001;
      K_SUBS: begin fs = 5'b01001; sl = 1'b1; end
      K_AND:  fs = 5'b00000;
      K_ANDS: sl = 1'b1;
      K_ORR:  fs = 5'b00100;
      K_EOR:  fs = 5'b01100;
      K_LSL:  begin fs = 5'b10000; bsel = 1'b1; k = 64'(o.sh); end
      K_LSR:  begin fs = 5'b10100; bsel = 1'b1; k = 64'(o.sh); end
      K_ADDI: begin fs = 5'b01000; bsel = 1'b1; k = 64'(o.i12); end
      K_SUBI: begin fs = 5'b01001; bsel = 1'b1; k = 64'(o.i12); end
      K_MOVZ: begin fs = 5'b00100; bsel = 1'b1; sa = 5'd31; k = 64'(o.i16) << (16 * o.hw); end
      K_LDUR: begin
        fs = 5'b01000; bsel = 1'b1; k = 64'(signed'(o.dt));
        if (ex1) begin e_mem = 1'b1; wr = 1'b1; ps = 2'b01; end
      end
      K_STUR: begin fs = 5'b01000; bsel = 1'b1; wm = 1'b1; sb = o.rd; ps = 2'b01; k = 64'(signed'(o.dt)); end
      K_B:    begin ps = 2'b10; k = 64'(signed'(o.i26)); end
      K_BL:   begin ps = 2'b10; k = 64'(signed'(o.i26)); e_pc = 1'b1; wr = 1'b1; da = 5'd30; end
      K_BR:   begin fs = 5'b00100; sb = 5'd31; ps = 2'b11; end
      K_CBZ:  begin fs = 5'b00100; sa = 5'd31; sb = o.rd; k = 64'(signed'(o.i19)); ps = st[0] ? 2'b10 : 2'b01; end
      K_CBNZ: begin fs = 5'b00100; sa = 5'd31; sb = o.rd; k = 64'(signed'(o.i19)); ps = st[0] ? 2'b01 : 2'b10; end
      K_BC:   begin k = 64'(signed'(o.i19)); ps = taken(o.cond, st) ? 2'b10 : 2'b01; end
      default: ;
    endcase
    return {k, e_pc, e_mem, e_alu, 1'b0, bsel, sl, wm, wr, ps, fs, sb, sa, da};
  endfunction
  function automatic op_t rand_op();
    op_t o;
    o.kind = ($urandom_range(0, 39) == 0) ? ($urandom_range(0, 1) ? K_ILL : K_ILLF) : int'($urandom_range(0, 20));
    o.rd = 5'($urandom); o.rn = 5'($urandom); o.rm = 5'($urandom);
    o.sh = 6'($urandom); o.i12 = 12'($urandom); o.i16 = 16'($urandom); o.hw = 2'($urandom);
    o.dt = 9'($urandom); o.i26 = 26'($urandom); o.i19 = 19'($urandom); o.cond = 4'($urandom);
    return o;
  endfunction
  task automatic step(op_t o, logic [4:0] st);
    exp_t e;
    logic [31:0] ins;
    bit ill;
    if (mst == 2) o = last_op;
    ins = enc(o);
    ill = o.kind == K_ILL || o.kind == K_ILLF;
    instruction = ins;
    status = st;
    e.st = 2'(mst);
    e.h = mst == 3;
    e.cw = (mst == 2 || (mst == 1 && !ill)) ? model_cw(o, ins, st, mst == 2) : '0;
    q.push_back(e);
    if (!reset) begin
      mst = 0; icnt = 0;
    end else if (mst == 0) begin
      if (icnt == IDLE_N - 1) mst = 1;
      else icnt++;
    end else if (mst == 1) mst = ill ? 3 : (o.kind == K_LDUR) ? 2 : 1;
    else if (mst == 2) mst = 1;
    last_op = o;
    @(posedge clock);
    #1;
  endtask
  task automatic do_reset(int n);
    reset = 1'b0;
    mst = 0;
    icnt = 0;
    repeat (n) step(rand_op(), 5'($urandom));
    reset = 1'b1;
  endtask
  always @(negedge clock) begin
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      vectors++;
      if (control_word !== mon_e.cw) begin
        miscompares++;
        $display("FAIL v%0d control_word got %h exp %h", vectors, control_word, mon_e.cw);
      end
      if (state !== mon_e.st) begin
        miscompares++;
        $display("FAIL v%0d state got %0d exp %0d", vectors, state, mon_e.st);
      end
      if (halted !== mon_e.h) begin
        miscompares++;
        $display("FAIL v%0d halted got %0b exp %0b", vectors, halted, mon_e.h);
      end
    end
  end
  initial begin
    op_t o;
    reset = 1'b0;
    instruction = '0;
    status = '0;
    @(posedge clock);
    #1;
    do_reset(3);
    o = rand_op(); o.kind = K_ADDI; o.rd = 5'd1; o.rn = 5'd31; o.i12 = 12'd5;
    step(o, 5'($urandom));
    step(o, 5'($urandom));
    o.kind = K_LDUR; o.rd = 5'd2; o.rn = 5'd1; o.dt = 9'h1F8;
    step(o, 5'($urandom));
    step(o, 5'($urandom));
    o.kind = K_CBZ; o.rd = 5'd3; o.i19 = 19'd4;
    step(o, 5'b00001);
    step(o, 5'b00000);
    o.kind = K_BC; o.cond = 4'd12; o.i19 = 19'h7FFFE;
    step(o, 5'b00000);
    step(o, 5'b00010);
    o.kind = K_LDUR;
    step(o, 5'($urandom));
    do_reset(2);
    for (int i = 0; i < 400; i++) begin
      step(rand_op(), 5'($urandom));
      if (mst == 3) begin
        step(rand_op(), 5'($urandom));
        step(rand_op(), 5'($urandom));
        do_reset(int'($urandom_range(1, 2)));
      end
    end
    o.kind = K_ILL;
    step(o, 5'($urandom));
    step(rand_op(), 5'($urandom));
    step(rand_op(), 5'($urandom));
    do_reset(1);
    step(rand_op(), 5'($urandom));
    step(rand_op(), 5'($urandom));
    repeat (2) @(negedge clock);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain queue got %0d pending exp 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
